apb_uart_fifo: RTL and testbench
================================

# apb_uart_fifo

APB3 slave UART with parameterised character width, TX/RX FIFO depth and baud-divider width. It is the FIFO-buffered successor to the single-register UART and keeps the same six-word register map, so existing driver sequences still run. It adds configurable parity, a second stop bit, RX threshold interrupts, and framing/parity error reporting. It connects to the peripheral APB bus; TXD/RXD go to pads or cross-connect to another UART instance.

## Interface
- DATA_BITS, 8, character width, 5..8
- FIFO_DEPTH, 8, entries per FIFO, power of 2, 2..128
- DIV_W, 16, baud divider width, ≥5
- PCLK  in  1  clock
- PRESET  in  1  reset. Synchronous and active-high: reset is sampled on the PCLK rising edge while high.
- PSEL, PENABLE, PWRITE  in  1  APB control
- PADDR  in  [11:2]  word address
- PWDATA  in  32  write data
- PRDATA  out  32  read data
- PREADY  out  1  tied 1
- PSLVERR  out  1  error on unmapped offset
- RXD  in  1  serial in, asynchronous, 2-flop synchronised
- TXD  out  1  serial out
- TXINT, RXINT, TXOVRINT, RXOVRINT, ERRINT  out  1  individual interrupts
- UARTINT  out  1  OR of the five interrupts

## Operation
Registers (word offset, reset 0):
- 0 DATA:
  - Write pushes PWDATA[DATA_BITS-1:0] into the TX FIFO.
  - Read pops the RX FIFO and returns data in [DATA_BITS-1:0] and that character's parity-error flag in bit 8.
  - Read when empty returns 0 and does not pop.
- 1 STATUS (read-only): [0] tx_full, [1] rx_not_empty, [2] tx_empty, [3] tx_busy, [15:8] tx_level, [23:16] rx_level.
- 2 CTRL: [0] tx_en, [1] rx_en, [2] txint_en, [3] rxint_en, [4] txovrint_en, [5] rxovrint_en, [6] errint_en, [15:8] rx_thresh.
- 3 INTSTAT:
  - Read: [0] tx, [1] rx, [2] txovr, [3] rxovr, [4] parerr, [5] frmerr.
  - Bits 2..5 are sticky and write-1-to-clear.
  - Bits 0..1 are live and not writable.
- 4 BAUDDIV [DIV_W-1:0]: PCLK cycles per bit. Values below 16 halt both FSMs in IDLE.
- 5 PARITY: [1:0] 00 none, 01 even, 10 odd, 11 none; [2] two stop bits.
- Offsets 6+: PSLVERR=1 in the access phase, the write is ignored, and PRDATA=0.

Interrupts:
- TXINT = txint_en & tx_empty & tx_en.
- RXINT = rxint_en & rx_level ≥ max(rx_thresh,1).
- TXOVRINT and RXOVRINT = sticky bit & its enable.
- ERRINT = (parerr|frmerr) & errint_en.

TX FSM (IDLE, START, DATA, PARITY, STOP):
- IDLE→START when tx_en, the TX FIFO is non-empty and BAUDDIV≥16. The FIFO pops on this transition.
- Each bit lasts BAUDDIV cycles. A bit counter restarts at each boundary; a boundary occurs when cnt ≥ BAUDDIV-1.
- Data is sent LSB first, for DATA_BITS bits.
- PARITY is skipped if parity is none.
- STOP lasts 1 or 2 bits, then the FSM returns to IDLE. It chains directly to START if data is pending.
- Clearing tx_en mid-frame lets the current frame finish; no further pops occur.

RX FSM (same states):
- In IDLE with rx_en, a synchronised falling edge enters START.
- Start bit is sampled at floor(BAUDDIV/2). If it reads high, this is a false start and the FSM returns to IDLE.
- Each later bit is sampled every BAUDDIV cycles.
- Parity mismatch: the character is stored with flag=1 and parerr is set.
- Stop sample = 0 (first stop bit only): the character is discarded and frmerr is set.
- Clearing rx_en aborts to IDLE and discards any partial character.

Boundary rules:
- TX write while full: dropped, txovr set.
- TX write while full in the same cycle as a TX pop: accepted, level unchanged.
- RX push while full: dropped, rxovr set.
- RX push while full in the same cycle as an APB pop: both occur, no overrun.
- Sticky set and W1C in the same cycle: set wins.
- BAUDDIV change takes effect at the next bit boundary.

## Timing
- APB: no wait states. Writes and pops commit on the PCLK edge where PSEL&PENABLE are high. PRDATA and PSLVERR are combinational during the access phase.
- DATA write committed at edge N with FSM idle: TXD goes low after edge N+1.
- RX character is pushed at the edge of its stop-bit sample. RXINT and rx_level update on that edge.
- RXD path has 2 cycles of synchroniser latency before edge detection.
- Reset values:
  - TXD=1; PRDATA=0; PSLVERR=0; PREADY=1; all interrupts 0.
  - FIFOs empty; FSMs IDLE; registers 0.
- Reset mid-frame forces TXD=1 the cycle after the reset edge and discards all FIFO contents.

## Test plan
- Loopback TXD→RXD, BAUDDIV=16, even parity, rx_en/tx_en, write 0x12 → TXD bits 0,0,1,0,0,1,0,0,0,0(parity),1; DATA read returns 0x012; RXINT high before the read.
- tx_en=0, write FIFO_DEPTH+1 characters → tx_full=1, tx_level=FIFO_DEPTH, TXOVRINT=1; write INTSTAT=0x4 → TXOVRINT=0.
- Receive FIFO_DEPTH+1 frames without reading → rx_level=FIFO_DEPTH, RXOVRINT=1; the first FIFO_DEPTH characters read back in order.
- Receiver set to odd parity, drive even-parity frame 0x55 → DATA read returns 0x155, ERRINT=1.
- RXD low pulse of 7 cycles at BAUDDIV=16 → no reception. Frame with stop=0 → nothing stored, INTSTAT[5]=1.
- BAUDDIV=0x1D4C → bit period 7500 cycles. Read offset 6 → PSLVERR=1, PRDATA=0. PRESET mid-frame → TXD=1 next cycle, STATUS=0x4.

Source files
------------

// File: rtl/apb_uart_fifo.sv
// apb_uart_fifo: APB3 slave UART with TX/RX FIFOs, configurable parity and stop bits,
// RX threshold interrupt and parity/framing error reporting.
//
// Ports:
//   PCLK, PRESET            clock, synchronous active-high reset
//   PSEL/PENABLE/PWRITE     APB control; PADDR word address; PWDATA write data
//   PRDATA, PREADY, PSLVERR APB response (no wait states; PSLVERR on unmapped offset)
//   RXD                     asynchronous serial input (2-flop synchronised)
//   TXD                     serial output, idle high
//   TXINT..ERRINT, UARTINT  individual interrupts and their OR
module apb_uart_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_W      = 16
) (
  input  logic         PCLK,
  input  logic         PRESET,
  input  logic         PSEL,
  input  logic         PENABLE,
  input  logic         PWRITE,
  input  logic [11:2]  PADDR,
  input  logic [31:0]  PWDATA,
  output logic [31:0]  PRDATA,
  output logic         PREADY,
  output logic         PSLVERR,
  input  logic         RXD,
  output logic         TXD,
  output logic         TXINT,
  output logic         RXINT,
  output logic         TXOVRINT,
  output logic         RXOVRINT,
  output logic         ERRINT,
  output logic         UARTINT
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // APB decode
  logic access, wr_en, rd_en, mapped;
  assign access = PSEL & PENABLE;
  assign wr_en  = access & PWRITE;
  assign rd_en  = access & ~PWRITE;
  assign mapped = PADDR < 10'd6;

  logic unused_pwdata;
  assign unused_pwdata = ^PWDATA;

  // Configuration and sticky status
  logic [15:0]      ctrl_q, ctrl_d;
  logic [DIV_W-1:0] baud_q, baud_d;
  logic [2:0]       par_q, par_d;
  logic [3:0]       sticky_q, sticky_d; // {frmerr, parerr, rxovr, txovr}

  logic tx_en, rx_en, parity_en, par_odd, two_stop, baud_ok;
  logic [7:0] rx_thresh_eff;
  assign tx_en     = ctrl_q[0];
  assign rx_en     = ctrl_q[1];
  assign parity_en = (par_q[1:0] == 2'b01) | (par_q[1:0] == 2'b10);
  assign par_odd   = (par_q[1:0] == 2'b10);
  assign two_stop  = par_q[2];
  assign baud_ok   = baud_q >= DIV_W'(16);
  assign rx_thresh_eff = (ctrl_q[15:8] == 8'd0) ? 8'd1 : ctrl_q[15:8];

  // TX FIFO
  logic [DATA_BITS-1:0] tx_mem_q [FIFO_DEPTH];
  logic [LW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d, tx_level;
  logic tx_full, tx_empty, tx_wr_req, tx_push, tx_pop, txovr_set;
  logic [DATA_BITS-1:0] tx_head;
  assign tx_level  = tx_wptr_q - tx_rptr_q;
  assign tx_full   = tx_level == LW'(FIFO_DEPTH);
  assign tx_empty  = tx_level == '0;
  assign tx_head   = tx_mem_q[tx_rptr_q[AW-1:0]];
  assign tx_wr_req = wr_en & (PADDR == 10'd0);
  // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
  assign tx_push   = tx_wr_req & (~tx_full | tx_pop);
  assign txovr_set = tx_wr_req & tx_full & ~tx_pop;
  assign tx_wptr_d = tx_push ? tx_wptr_q + LW'(1) : tx_wptr_q;
  assign tx_rptr_d = tx_pop ? tx_rptr_q + LW'(1) : tx_rptr_q;

  // RX FIFO, entries are {parity_error, data}
  logic [DATA_BITS:0] rx_mem_q [FIFO_DEPTH];
  logic [LW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d, rx_level;
  logic rx_full, rx_empty, rx_push, rx_accept, rx_pop, rxovr_set;
  logic [DATA_BITS:0] rx_head, rx_push_data;
  assign rx_level  = rx_wptr_q - rx_rptr_q;
  assign rx_full   = rx_level == LW'(FIFO_DEPTH);
  assign rx_empty  = rx_level == '0;
  assign rx_head   = rx_mem_q[rx_rptr_q[AW-1:0]];
  assign rx_pop    = rd_en & (PADDR == 10'd0) & ~rx_empty;
  assign rx_accept = rx_push & (~rx_full | rx_pop);
  assign rxovr_set = rx_push & rx_full & ~rx_pop;
  assign rx_wptr_d = rx_accept ? rx_wptr_q + LW'(1) : rx_wptr_q;
  assign rx_rptr_d = rx_pop ? rx_rptr_q + LW'(1) : rx_rptr_q;

  // TX FSM
  state_e               tx_state_q, tx_state_d;
  logic [DIV_W-1:0]     tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_pbit_q, tx_pbit_d, tx_stop2_q, tx_stop2_d;
  logic                 tx_bnd, tx_start_ok;
  assign tx_bnd      = tx_cnt_q >= tx_div_q - DIV_W'(1);
  assign tx_start_ok = tx_en & ~tx_empty & baud_ok;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_bnd ? '0 : tx_cnt_q + DIV_W'(1);
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_pbit_d  = tx_pbit_q;
    tx_stop2_d = tx_stop2_q;
    tx_pop     = 1'b0;
    // Divider changes are only picked up at a bit boundary.
    if (tx_state_q != StIdle && tx_bnd && baud_ok) tx_div_d = baud_q;
    unique case (tx_state_q)
      StIdle: begin
        tx_cnt_d = '0;
        if (tx_start_ok) begin
          tx_pop     = 1'b1;
          tx_state_d = StStart;
          tx_sh_d    = tx_head;
          tx_pbit_d  = (^tx_head) ^ par_odd;
          tx_div_d   = baud_q;
        end
      end
      StStart: begin
        if (tx_bnd) begin
          tx_state_d = StData;
          tx_bit_d   = '0;
        end
      end
      StData: begin
        if (tx_bnd) begin
          tx_sh_d = tx_sh_q >> 1;
          if (tx_bit_q == 3'(DATA_BITS - 1)) begin
            tx_state_d = parity_en ? StParity : StStop;
            tx_stop2_d = 1'b0;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (tx_bnd) begin
          tx_state_d = StStop;
          tx_stop2_d = 1'b0;
        end
      end
      StStop: begin
        if (tx_bnd) begin
          if (two_stop && !tx_stop2_q) begin
            tx_stop2_d = 1'b1;
          end else if (tx_start_ok) begin
            // Back-to-back frame: go straight to the next start bit.
            tx_pop     = 1'b1;
            tx_state_d = StStart;
            tx_sh_d    = tx_head;
            tx_pbit_d  = (^tx_head) ^ par_odd;
            tx_div_d   = baud_q;
          end else begin
            tx_state_d = StIdle;
          end
        end
      end
      default: tx_state_d = StIdle;
    endcase
  end

  always_comb begin
    unique case (tx_state_q)
      StStart:  TXD = 1'b0;
      StData:   TXD = tx_sh_q[0];
      StParity: TXD = tx_pbit_q;
      default:  TXD = 1'b1;
    endcase
  end

  // RX synchroniser and FSM
  logic rxd_s1_q, rxd_s2_q, rxd_prev_q, rx_fall;
  assign rx_fall = rxd_prev_q & ~rxd_s2_q;

  state_e               rx_state_q, rx_state_d;
  logic [DIV_W-1:0]     rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic                 rx_pbit_q, rx_pbit_d, rx_bnd, rx_perr, parerr_set, frmerr_set;
  assign rx_bnd  = rx_cnt_q >= rx_div_q - DIV_W'(1);
  assign rx_perr = parity_en & ((^rx_sh_q) ^ rx_pbit_q ^ par_odd);

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_bnd ? '0 : rx_cnt_q + DIV_W'(1);
    rx_div_d     = rx_div_q;
    rx_bit_d     = rx_bit_q;
    rx_sh_d      = rx_sh_q;
    rx_pbit_d    = rx_pbit_q;
    rx_push      = 1'b0;
    rx_push_data = {rx_perr, rx_sh_q};
    parerr_set   = 1'b0;
    frmerr_set   = 1'b0;
    if (rx_state_q != StIdle && rx_state_q != StStart && rx_bnd && baud_ok) rx_div_d = baud_q;
    if (!rx_en) begin
      rx_state_d = StIdle;
      rx_cnt_d   = '0;
    end else begin
      unique case (rx_state_q)
        StIdle: begin
          rx_cnt_d = '0;
          if (rx_fall && baud_ok) begin
            rx_state_d = StStart;
            rx_div_d   = baud_q;
          end
        end
        StStart: begin
          // Mid-bit check of the start bit; later samples are a whole bit apart.
          rx_cnt_d = rx_cnt_q + DIV_W'(1);
          if (rx_cnt_q == (rx_div_q >> 1)) begin
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
            rx_state_d = rxd_s2_q ? StIdle : StData;
            if (baud_ok) rx_div_d = baud_q;
          end
        end
        StData: begin
          if (rx_bnd) begin
            rx_sh_d = {rxd_s2_q, rx_sh_q[DATA_BITS-1:1]};
            if (rx_bit_q == 3'(DATA_BITS - 1)) begin
              rx_state_d = parity_en ? StParity : StStop;
            end else begin
              rx_bit_d = rx_bit_q + 3'd1;
            end
          end
        end
        StParity: begin
          if (rx_bnd) begin
            rx_pbit_d  = rxd_s2_q;
            rx_state_d = StStop;
          end
        end
        StStop: begin
          // Only the first stop bit is checked; return to idle right away.
          if (rx_bnd) begin
            rx_state_d = StIdle;
            if (rxd_s2_q) begin
              rx_push    = 1'b1;
              parerr_set = rx_perr;
            end else begin
              frmerr_set = 1'b1;
            end
          end
        end
        default: rx_state_d = StIdle;
      endcase
    end
  end

  // Register writes; a sticky set in the same cycle as its clear wins.
  always_comb begin
    logic [3:0] w1c;
    ctrl_d = ctrl_q;
    baud_d = baud_q;
    par_d  = par_q;
    w1c    = (wr_en && PADDR == 10'd3) ? PWDATA[5:2] : 4'b0;
    sticky_d = (sticky_q & ~w1c) | {frmerr_set, parerr_set, rxovr_set, txovr_set};
    if (wr_en) begin
      case (PADDR)
        10'd2:   ctrl_d = {PWDATA[15:8], 1'b0, PWDATA[6:0]};
        10'd4:   baud_d = PWDATA[DIV_W-1:0];
        10'd5:   par_d  = PWDATA[2:0];
        default: ;
      endcase
    end
  end

  // Interrupts
  logic tx_irq_raw, rx_irq_raw;
  assign tx_irq_raw = tx_empty & tx_en;
  assign rx_irq_raw = 8'(rx_level) >= rx_thresh_eff;
  assign TXINT    = ctrl_q[2] & tx_irq_raw;
  assign RXINT    = ctrl_q[3] & rx_irq_raw;
  assign TXOVRINT = ctrl_q[4] & sticky_q[0];
  assign RXOVRINT = ctrl_q[5] & sticky_q[1];
  assign ERRINT   = ctrl_q[6] & (sticky_q[2] | sticky_q[3]);
  assign UARTINT  = TXINT | RXINT | TXOVRINT | RXOVRINT | ERRINT;

  // Read mux
  assign PREADY  = 1'b1;
  assign PSLVERR = access & ~mapped;

  always_comb begin
    PRDATA = '0;
    if (rd_en) begin
      case (PADDR)
        10'd0: begin
          if (!rx_empty) begin
            PRDATA[DATA_BITS-1:0] = rx_head[DATA_BITS-1:0];
            PRDATA[8]             = rx_head[DATA_BITS];
          end
        end
        10'd1: begin
          PRDATA[0]     = tx_full;
          PRDATA[1]     = ~rx_empty;
          PRDATA[2]     = tx_empty;
          PRDATA[3]     = tx_state_q != StIdle;
          PRDATA[15:8]  = 8'(tx_level);
          PRDATA[23:16] = 8'(rx_level);
        end
        10'd2:   PRDATA[15:0] = ctrl_q;
        10'd3:   PRDATA[5:0]  = {sticky_q, rx_irq_raw, tx_irq_raw};
        10'd4:   PRDATA[DIV_W-1:0] = baud_q;
        10'd5:   PRDATA[2:0] = par_q;
        default: ;
      endcase
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge PCLK) begin
    if (tx_push) tx_mem_q[tx_wptr_q[AW-1:0]] <= PWDATA[DATA_BITS-1:0];
    if (rx_accept) rx_mem_q[rx_wptr_q[AW-1:0]] <= rx_push_data;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ctrl_q     <= '0;
      baud_q     <= '0;
      par_q      <= '0;
      sticky_q   <= '0;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_div_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_pbit_q  <= 1'b0;
      tx_stop2_q <= 1'b0;
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_div_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_pbit_q  <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      baud_q     <= baud_d;
      par_q      <= par_d;
      sticky_q   <= sticky_d;
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_pbit_q  <= tx_pbit_d;
      tx_stop2_q <= tx_stop2_d;
      rxd_s1_q   <= RXD;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_pbit_q  <= rx_pbit_d;
    end
  end

endmodule

// File: tb/tb_apb_uart_fifo.sv
// Directed testbench for apb_uart_fifo (DATA_BITS=8, FIFO_DEPTH=8, DIV_W=16).
module tb_apb_uart_fifo;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [11:2] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, TXD;
  logic        TXINT, RXINT, TXOVRINT, RXOVRINT, ERRINT, UARTINT;
  logic        loop_en = 1'b0, rxd_drv = 1'b1, rxd_w;

  assign rxd_w = loop_en ? TXD : rxd_drv;

  apb_uart_fifo #(.DATA_BITS(8), .FIFO_DEPTH(8), .DIV_W(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .RXD(rxd_w), .TXD(TXD), .TXINT(TXINT), .RXINT(RXINT), .TXOVRINT(TXOVRINT),
    .RXOVRINT(RXOVRINT), .ERRINT(ERRINT), .UARTINT(UARTINT)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // Returns 1 ns after the commit edge.
  task automatic apb_write(input logic [9:0] a, input logic [31:0] d);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [9:0] a, output logic [31:0] d, output logic err);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    d = PRDATA;
    err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic hold_bit(input logic v);
    rxd_drv = v;
    wait_cycles(16);
  endtask

  // par: 0 none, 1 even, 2 odd. Frame bit period is 16 cycles.
  task automatic send_frame(input logic [7:0] d, input int par, input logic stop);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(d[i]);
    if (par != 0) hold_bit((^d) ^ (par == 2));
    hold_bit(stop);
    rxd_drv = 1'b1;
    wait_cycles(32);
  endtask

  task automatic do_reset();
    PRESET = 1'b1;
    wait_cycles(2);
    PRESET = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    logic [10:0] txbits;
    int          cnt;

    // Reset state
    wait_cycles(3);
    check_eq("rst_txd", {31'b0, TXD}, 32'h1);
    check_eq("rst_pready", {31'b0, PREADY}, 32'h1);
    check_eq("rst_uartint", {31'b0, UARTINT}, 32'h0);
    check_eq("rst_prdata", PRDATA, 32'h0);
    check_eq("rst_pslverr", {31'b0, PSLVERR}, 32'h0);
    PRESET = 1'b0;
    apb_read(10'd1, rd, err);
    check_eq("rst_status", rd, 32'h4);
    check_eq("rst_status_err", {31'b0, err}, 32'h0);

    // Loopback, even parity, 0x12
    loop_en = 1'b1;
    apb_write(10'd4, 32'd16);
    apb_write(10'd5, 32'h1);
    apb_write(10'd2, 32'h0B);
    apb_write(10'd0, 32'h12);
    check_eq("tx_idle_at_commit", {31'b0, TXD}, 32'h1);
    wait_cycles(1);
    check_eq("tx_start_next_edge", {31'b0, TXD}, 32'h0);
    wait_cycles(8);
    txbits[0] = TXD;
    for (int i = 1; i < 11; i++) begin
      wait_cycles(16);
      txbits[i] = TXD;
    end
    check_eq("tx_frame_bits", {21'b0, txbits}, 32'h424);
    wait_cycles(16);
    check_eq("loop_rxint", {31'b0, RXINT}, 32'h1);
    apb_read(10'd0, rd, err);
    check_eq("loop_data", rd, 32'h012);
    check_eq("loop_rxint_after", {31'b0, RXINT}, 32'h0);

    // TX overflow with tx_en=0
    loop_en = 1'b0;
    do_reset();
    apb_write(10'd4, 32'd16);
    apb_write(10'd2, 32'h10);
    for (int i = 0; i < 9; i++) apb_write(10'd0, i);
    apb_read(10'd1, rd, err);
    check_eq("txfull_status", rd, 32'h0801);
    check_eq("txovrint", {31'b0, TXOVRINT}, 32'h1);
    check_eq("txovr_uartint", {31'b0, UARTINT}, 32'h1);
    apb_read(10'd3, rd, err);
    check_eq("txovr_intstat", rd, 32'h4);
    apb_write(10'd3, 32'h4);
    check_eq("txovrint_clr", {31'b0, TXOVRINT}, 32'h0);
    apb_read(10'd3, rd, err);
    check_eq("intstat_clr", rd, 32'h0);

    // Reset mid-frame
    apb_write(10'd2, 32'h01);
    wait_cycles(40);
    check_eq("txd_mid_frame", {31'b0, TXD}, 32'h0);
    PRESET = 1'b1;
    wait_cycles(1);
    check_eq("txd_after_reset", {31'b0, TXD}, 32'h1);
    PRESET = 1'b0;
    apb_read(10'd1, rd, err);
    check_eq("status_after_reset", rd, 32'h4);

    // RX overflow: 9 frames, no reads
    apb_write(10'd4, 32'd16);
    apb_write(10'd2, 32'h22);
    for (int i = 0; i < 9; i++) send_frame(8'(8'h30 + i), 0, 1'b1);
    apb_read(10'd1, rd, err);
    check_eq("rxfull_status", rd, 32'h00080006);
    check_eq("rxovrint", {31'b0, RXOVRINT}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      apb_read(10'd0, rd, err);
      check_eq($sformatf("rx_order_%0d", i), rd, 32'h30 + i);
    end
    apb_read(10'd1, rd, err);
    check_eq("rx_drained", rd, 32'h4);
    apb_write(10'd3, 32'h8);
    check_eq("rxovrint_clr", {31'b0, RXOVRINT}, 32'h0);

    // Odd-parity receiver, even-parity frame
    apb_write(10'd5, 32'h2);
    apb_write(10'd2, 32'h42);
    send_frame(8'h55, 1, 1'b1);
    check_eq("errint", {31'b0, ERRINT}, 32'h1);
    apb_read(10'd0, rd, err);
    check_eq("parerr_data", rd, 32'h155);
    apb_read(10'd3, rd, err);
    check_eq("parerr_intstat", rd, 32'h10);
    apb_write(10'd3, 32'h10);
    check_eq("errint_clr", {31'b0, ERRINT}, 32'h0);

    // Glitch rejection and framing error
    apb_write(10'd5, 32'h0);
    apb_write(10'd2, 32'h02);
    rxd_drv = 1'b0;
    wait_cycles(7);
    rxd_drv = 1'b1;
    wait_cycles(200);
    apb_read(10'd1, rd, err);
    check_eq("glitch_status", rd, 32'h4);
    send_frame(8'hA5, 0, 1'b0);
    apb_read(10'd1, rd, err);
    check_eq("frmerr_status", rd, 32'h4);
    apb_read(10'd3, rd, err);
    check_eq("frmerr_intstat", rd, 32'h20);

    // Long bit period, unmapped offset
    do_reset();
    apb_write(10'd4, 32'h1D4C);
    apb_read(10'd4, rd, err);
    check_eq("bauddiv_rd", rd, 32'h1D4C);
    apb_write(10'd2, 32'h01);
    apb_write(10'd0, 32'h01);
    cnt = 0;
    for (int i = 0; i < 10 && TXD; i++) wait_cycles(1);
    while (TXD == 1'b0 && cnt < 20000) begin
      wait_cycles(1);
      cnt++;
    end
    check_eq("bit_period", cnt, 32'd7500);
    apb_read(10'd6, rd, err);
    check_eq("unmapped_pslverr", {31'b0, err}, 32'h1);
    check_eq("unmapped_prdata", rd, 32'h0);
    PRESET = 1'b1;
    wait_cycles(1);
    check_eq("slow_reset_txd", {31'b0, TXD}, 32'h1);
    PRESET = 1'b0;
    apb_read(10'd1, rd, err);
    check_eq("slow_reset_status", rd, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
